// File: rtl/clk_period_meter.sv
// Measures the rising-to-rising period of a slow asynchronous signal in clk cycles.
// Emits a tick per rising edge, a period_valid pulse per measurement, and timeout/locked status.
module clk_period_meter #(
  parameter int unsigned W           = 32,
  parameter int unsigned TIMEOUT     = 100000000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         sig_in,
  output logic         tick,
  output logic [W-1:0] period,
  output logic         period_valid,
  output logic         timeout,
  output logic         locked
);

  typedef enum logic [1:0] {StIdle, StArm, StMeas} state_e;

  localparam logic [W-1:0] CntMax = W'(TIMEOUT - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   edge_det;
  state_e                 state_q;
  logic [W-1:0]           cnt_q;

  // Synchronizer and history run independently of en, so a level already high at enable is no edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_det = sync_q[SYNC_STAGES-1] & ~hist_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      period       <= '0;
      tick         <= 1'b0;
      period_valid <= 1'b0;
      timeout      <= 1'b0;
      locked       <= 1'b0;
    end else begin
      tick         <= en & edge_det;
      period_valid <= 1'b0;
      if (!en) begin
        state_q <= StIdle;
        cnt_q   <= '0;
        timeout <= 1'b0;
        locked  <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            cnt_q   <= '0;
            state_q <= StArm;
          end
          StArm: begin
            cnt_q <= '0;
            if (edge_det) begin
              state_q <= StMeas;
            end
          end
          StMeas: begin
            // An edge on the final count still counts as a measurement of exactly TIMEOUT.
            if (edge_det) begin
              period       <= cnt_q + W'(1);
              period_valid <= 1'b1;
              cnt_q        <= '0;
              timeout      <= 1'b0;
              locked       <= 1'b1;
            end else if (cnt_q == CntMax) begin
              timeout <= 1'b1;
              locked  <= 1'b0;
              cnt_q   <= '0;
              state_q <= StArm;
            end else begin
              cnt_q <= cnt_q + W'(1);
            end
          end
          default: begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_clk_period_meter.sv
// Bench for clk_period_meter: directed phases plus random waveforms, checked each cycle
// against a model that tracks edge timestamps rather than a counter.
module tb_clk_period_meter;

  localparam int unsigned WW = 16;
  localparam int unsigned TO = 50;
  localparam int unsigned SS = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic          sig_in = 1'b0;
  logic          tick;
  logic [WW-1:0] period;
  logic          period_valid;
  logic          timeout;
  logic          locked;

  int checks = 0;
  int errors = 0;

  clk_period_meter #(
    .W          (WW),
    .TIMEOUT    (TO),
    .SYNC_STAGES(SS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .sig_in      (sig_in),
    .tick        (tick),
    .period      (period),
    .period_valid(period_valid),
    .timeout     (timeout),
    .locked      (locked)
  );

  always #5 clk = ~clk;

  // Model state: sampled-input history, current time, time of last edge, mode 0 idle/1 armed/2 meas.
  bit            hist[0:SS];
  int            now_t;
  int            last_t;
  int            mode;
  logic          m_tick, m_pv, m_to, m_lock;
  logic [WW-1:0] m_per;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i <= SS; i++) hist[i] = 1'b0;
    mode = 0; m_tick = 0; m_pv = 0; m_to = 0; m_lock = 0; m_per = '0;
  endtask

  task automatic model_step();
    bit rise;
    // An edge is seen SS samples late: newest-before-last synchronized sample high, the older one low.
    rise = hist[SS-1] & ~hist[SS];
    for (int i = SS; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = sig_in;
    now_t++;
    m_pv = 1'b0;
    if (!en) begin
      mode = 0; m_tick = 0; m_to = 0; m_lock = 0;
    end else begin
      m_tick = rise;
      if (mode == 0) begin
        mode = 1;
      end else if (mode == 1) begin
        if (rise) begin
          mode = 2; last_t = now_t;
        end
      end else begin
        if (rise) begin
          m_per = WW'(now_t - last_t); m_pv = 1; m_to = 0; m_lock = 1; last_t = now_t;
        end else if (now_t - last_t == int'(TO)) begin
          m_to = 1; m_lock = 0; mode = 1;
        end
      end
    end
  endtask

  task automatic compare_all();
    chk("tick", 32'(tick), 32'(m_tick));
    chk("period_valid", 32'(period_valid), 32'(m_pv));
    chk("period", 32'(period), 32'(m_per));
    chk("timeout", 32'(timeout), 32'(m_to));
    chk("locked", 32'(locked), 32'(m_lock));
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst) model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic drive(input logic s, input logic e, input int n);
    sig_in = s;
    en     = e;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic square(input int hi, input int lo, input int reps);
    for (int r = 0; r < reps; r++) begin
      drive(1'b1, 1'b1, hi);
      drive(1'b0, 1'b1, lo);
    end
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    @(negedge clk);
    compare_all();
    rst = 1'b0;
  endtask

  initial begin
    now_t  = 0;
    last_t = 0;
    model_reset();
    drive(1'b0, 1'b0, 2);
    reset_pulse();

    // Period 10, then switch to 24 mid-run.
    square(5, 5, 8);
    chk("p10", 32'(period), 10);
    chk("lock10", 32'(locked), 1);
    square(12, 12, 6);
    chk("p24", 32'(period), 24);
    chk("to24", 32'(timeout), 0);

    // Edges 30 apart, then held low past the timeout, then recover.
    square(15, 15, 3);
    drive(1'b0, 1'b1, 80);
    chk("p30_hold", 32'(period), 30);
    chk("to_set", 32'(timeout), 1);
    chk("unlock", 32'(locked), 0);
    square(15, 15, 2);
    chk("to_clr", 32'(timeout), 0);

    // Edges exactly TIMEOUT apart.
    square(25, 25, 6);
    chk("p50", 32'(period), 50);
    chk("to50", 32'(timeout), 0);

    // sig_in already high at enable, then en dropped mid-measurement.
    drive(1'b1, 1'b0, 10);
    drive(1'b1, 1'b1, 20);
    drive(1'b0, 1'b1, 10);
    square(10, 10, 4);
    drive(1'b1, 1'b0, 5);
    chk("en_off_lock", 32'(locked), 0);
    chk("en_off_per", 32'(period), 20);
    drive(1'b0, 1'b1, 10);

    // Reset between edges.
    square(12, 12, 3);
    drive(1'b1, 1'b1, 6);
    reset_pulse();
    drive(1'b1, 1'b1, 6);
    drive(1'b0, 1'b1, 12);
    square(12, 12, 3);
    chk("p_after_rst", 32'(period), 24);

    // Random waveforms with occasional enable drops and resets.
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 39) == 0) reset_pulse();
      if ($urandom_range(0, 19) == 0) drive(sig_in, 1'b0, $urandom_range(1, 8));
      drive(1'b1, 1'b1, $urandom_range(1, 30));
      drive(1'b0, 1'b1, $urandom_range(1, 40));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_period_meter.md
Name: clk_period_meter

Overview:
Receive-side companion to the clock divider. It takes a slow clock or square wave (a divided clock, an external oscillator or a test signal) into the fast clk domain through a synchronizer. It emits a one-cycle tick on each rising edge and measures the rising-to-rising period in clk cycles. Used to self-check divider outputs and to derive single-cycle enables for the SPM and display logic.

Parameters:
W, 32, width of the period counter and period output
TIMEOUT, 100000000, max clk cycles between edges before the timeout flag sets; must satisfy 2 <= TIMEOUT <= 2^W-1
SYNC_STAGES, 2, synchronizer flop count on sig_in; legal range 2..4

Ports:
clk  input  1  fast system clock
rst  input  1  reset, asynchronous, active-high
en  input  1  measurement enable, synchronous
sig_in  input  1  slow signal to measure, asynchronous to clk
tick  output  1  one-cycle pulse per detected rising edge of sig_in
period  output  W  last measured period in clk cycles
period_valid  output  1  one-cycle pulse when period is updated
timeout  output  1  sticky flag: no edge within TIMEOUT cycles
locked  output  1  high once at least one period measured since last arm

Behaviour:
- Reset (async): sync chain, history flop, cnt, period, tick, period_valid, timeout and locked all clear to 0; state = IDLE.
- Synchronizer: sig_in passes through SYNC_STAGES flops, then one history flop. edge_det = last_stage & ~history.
- The synchronizer runs whenever rst is low, regardless of en. So sig_in already high when en rises produces no edge.
- tick is registered from edge_det and qualified by en. If sig_in is first sampled high at clk edge 0 (previously low), tick is high for the single cycle after clk edge SYNC_STAGES.
- FSM states IDLE, ARM, MEAS:
  - IDLE: cnt=0. en=1 -> ARM.
  - ARM: cnt held at 0. On edge_det, cnt<=0 and go to MEAS; no period_valid.
  - MEAS: cnt increments by 1 every cycle.
    - On edge_det: period<=cnt+1, period_valid pulses for 1 cycle, cnt<=0, timeout<=0, locked<=1; stay in MEAS. period therefore equals the exact cycle distance between successive edge detections.
    - If cnt==TIMEOUT-1 and no edge_det: timeout<=1, locked<=0, cnt<=0, go to ARM; period holds its old value.
  - en=0 in any state: next state IDLE, cnt<=0, timeout<=0, locked<=0, tick and period_valid forced 0; period retained.
- Simultaneous edge_det and cnt==TIMEOUT-1 in MEAS: the edge wins, period=TIMEOUT, no timeout.
- cnt never exceeds TIMEOUT-1, so no wrap-around in W bits.
- period_valid and tick assert in the same cycle for a measuring edge.
- Latency: period and period_valid update on the clock edge after edge_det, aligned with tick.
- Reset mid-measurement discards the partial count; the first edge after reset only arms.

Test Plan:
- Reset, en=1, sig_in square wave period 10 clk (5 high / 5 low) -> first edge gives tick only. Every later edge gives tick+period_valid with period=10; locked=1 after the second edge.
- Switch sig_in to period 24 mid-run -> the first measurement spans the transition interval. All following measurements give period=24 and timeout stays 0.
- TIMEOUT=50, two edges 30 cycles apart then sig_in held low -> period=30. timeout=1 and locked=0 exactly 50 cycles after the last edge detection; period stays 30. The next two edges clear timeout and give a new period.
- TIMEOUT=50, edges exactly 50 cycles apart -> period=50, timeout never sets.
- sig_in held high, en raised 0->1 -> no tick until sig_in falls and rises again. en dropped mid-MEAS -> tick, period_valid and locked go 0, period retained.
- Assert rst for 1 cycle between edges -> all outputs 0 immediately. The next edge arms with no period_valid; the edge after that reports the true period.
